time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Pushbutton front end that writes a new time into the running clock. It is the input side of the display path: ledctrl reads time from the clock, and this block loads time into it. It debounces three raw keys and steps through hour, minute and second edit fields. On commit it emits a one-cycle load pulse with the edited values, and it holds the clock's enable low while editing.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples required before a key level is accepted (10 ms at 50 MHz).
TIMEOUT_SECS, 30, number of sec_pulse ticks with no accepted key press before an edit is abandoned.

Ports:
clk  in  1  system clock, the same clk that drives clockdivider.
reset_n  in  1  asynchronous, active-low reset.
sec_pulse  in  1  one-cycle tick per second from clockdivider.
key_mode_n  in  1  raw mode pushbutton, active-low, asynchronous.
key_inc_n  in  1  raw increment pushbutton, active-low, asynchronous.
key_dec_n  in  1  raw decrement pushbutton, active-low, asynchronous.
cur_sec  in  6  running seconds from the clock, 0..59.
cur_min  in  6  running minutes from the clock, 0..59.
cur_hour  in  5  running hours from the clock, 0..23.
clk_enable  out  1  drives the clock's enable; 1 in RUN, 0 while editing.
load  out  1  one-cycle strobe; the clock takes load_* when this is high.
load_sec  out  6  edited seconds.
load_min  out  6  edited minutes.
load_hour  out  5  edited hours.
edit_field  out  2  field under edit for ledctrl blinking: 0 = none, 1 = hour, 2 = min, 3 = sec.

Behaviour:
- Reset (async assert, sync release): FSM goes to RUN. clk_enable = 1, load = 0, load_* = 0, edit_field = 0. Debouncer state is cleared to "released". Timeout counter = 0.
- Each key path: a 2-FF synchroniser, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current accepted level.
  - Any sample equal to the accepted level resets the counter.
  - A press pulse is one cycle, on the released-to-pressed transition only. There is no auto-repeat.
  - Latency from a stable raw edge to the press pulse is DEBOUNCE_CYCLES + 3 cycles.
- FSM states and transitions:
  - RUN --mode--> SET_HOUR. On the same cycle, capture cur_* into the edit registers.
  - SET_HOUR --mode--> SET_MIN.
  - SET_MIN --mode--> SET_SEC.
  - SET_SEC --mode--> RUN, with load = 1 for exactly one cycle. load_* hold the edit registers and stay stable afterwards.
  - Any SET_* state --timeout--> RUN with no load pulse. The clock resumes its own running count.
- Edit arithmetic, applied to the current field only:
  - Hour wraps 23 -> 0 on inc and 0 -> 23 on dec.
  - Minute and second wrap 59 -> 0 and 0 -> 59.
  - Edit values never leave their legal range.
- Keys in RUN: inc and dec are ignored.
- Simultaneous events in one cycle:
  - mode + inc/dec: mode wins and inc/dec are discarded.
  - inc + dec: no change.
  - Timeout + mode: mode wins.
- Timeout:
  - The counter increments on sec_pulse in SET_* states.
  - It clears on any accepted press and on entering RUN.
  - Abort fires when the count reaches TIMEOUT_SECS.
- Outputs:
  - clk_enable = (state == RUN). It goes high in the same cycle load is asserted, so the clock loads and then resumes.
  - edit_field is a registered copy of the state encoding.
- Reset mid-edit: edit values are discarded, with no load pulse; reset values apply immediately.

Decomposition:
- clock_pkg: enum set_state_t {RUN, SET_HOUR, SET_MIN, SET_SEC}, 2-bit, using the same encoding as edit_field.
- clock_pkg constants: SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
- clock_pkg width constants: SEC_W = 6, MIN_W = 6, HOUR_W = 5. Shared with the clock and ledctrl.
- Sub-module key_debounce (synchroniser, debounce counter, press pulse), instantiated three times.
- The FSM, edit registers and timeout counter live in time_set_ctrl.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4 and TIMEOUT_SECS = 3.
- Reset with reset_n low mid-cycle -> outputs at reset values asynchronously; clk_enable = 1, edit_field = 0.
- Bounce: key_inc_n toggling every 2 cycles for 20 cycles, then held low -> exactly one press pulse, 7 cycles after the last edge.
- Full edit: cur = 12:34:56; press mode, inc x12 (hour 12 -> 0), mode, dec x35 (min 34 -> 59), mode, inc x4 (sec 56 -> 0), mode -> single-cycle load with 00:59:00; clk_enable low during SET_*; edit_field sequence 1, 2, 3, 0.
- Simultaneous: inc and dec accepted on the same cycle in SET_MIN at 10 -> min stays 10. mode and inc on the same cycle in SET_HOUR at 5 -> state SET_MIN, hour stays 5.
- Timeout: enter SET_HOUR, give no keys, issue 3 sec_pulse -> RUN, no load, clk_enable = 1. Repeat with a key press after 2 pulses -> no abort until 3 further pulses.
- Reset mid-edit in SET_SEC -> RUN, load never asserted, load_* = 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: field widths, field limits,
// the time-set FSM encoding, and modular increment/decrement helpers.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // Encoding matches edit_field so the state can be exported unchanged.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } set_state_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
    return (v == 6'd0 || v > max_v) ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton path: 2-FF synchroniser, stability counter and a
// single-cycle pulse on each accepted released-to-pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    // Once the counter holds DEBOUNCE_CYCLES differing samples, the level flips.
    if (cnt_q == CNT_DONE) begin
      pressed_d = ~pressed_q;
      press_d   = ~pressed_q;
      cnt_d     = '0;
    end else if ((~sync2_q) == pressed_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set front end: debounced mode/inc/dec keys drive an hour/min/sec
// edit FSM that loads the running clock on commit or abandons on timeout.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_SECS    = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sec_pulse,
  input  logic              key_mode_n,
  input  logic              key_inc_n,
  input  logic              key_dec_n,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] cur_hour,
  output logic              clk_enable,
  output logic              load,
  output logic [SEC_W-1:0]  load_sec,
  output logic [MIN_W-1:0]  load_min,
  output logic [HOUR_W-1:0] load_hour,
  output logic [1:0]        edit_field
);

  localparam int TO_W = $clog2(TIMEOUT_SECS + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_SECS);

  logic press_mode, press_inc, press_dec;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset_n(reset_n), .key_n(key_mode_n), .press(press_mode));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset_n(reset_n), .key_n(key_inc_n), .press(press_inc));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .reset_n(reset_n), .key_n(key_dec_n), .press(press_dec));

  set_state_t        state_q, state_d;
  logic [SEC_W-1:0]  edit_sec_q, edit_sec_d;
  logic [MIN_W-1:0]  edit_min_q, edit_min_d;
  logic [HOUR_W-1:0] edit_hour_q, edit_hour_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              load_q, load_d;
  logic [SEC_W-1:0]  load_sec_q, load_sec_d;
  logic [MIN_W-1:0]  load_min_q, load_min_d;
  logic [HOUR_W-1:0] load_hour_q, load_hour_d;
  logic              clk_enable_q;
  logic [1:0]        edit_field_q;
  logic              step_up, step_dn;

  // inc and dec together cancel out but still count as activity.
  assign step_up = press_inc & ~press_dec;
  assign step_dn = press_dec & ~press_inc;

  always_comb begin
    state_d     = state_q;
    edit_sec_d  = edit_sec_q;
    edit_min_d  = edit_min_q;
    edit_hour_d = edit_hour_q;
    timeout_d   = timeout_q;
    load_d      = 1'b0;
    load_sec_d  = load_sec_q;
    load_min_d  = load_min_q;
    load_hour_d = load_hour_q;
    if (state_q == RUN) begin
      timeout_d = '0;
      if (press_mode) begin
        state_d     = SET_HOUR;
        edit_sec_d  = cur_sec;
        edit_min_d  = cur_min;
        edit_hour_d = cur_hour;
      end
    end else if (press_mode) begin
      timeout_d = '0;
      case (state_q)
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default: begin
          state_d     = RUN;
          load_d      = 1'b1;
          load_sec_d  = edit_sec_q;
          load_min_d  = edit_min_q;
          load_hour_d = edit_hour_q;
        end
      endcase
    end else if (timeout_q == TO_LIMIT) begin
      state_d   = RUN;
      timeout_d = '0;
    end else begin
      case (state_q)
        SET_HOUR: begin
          if (step_up) edit_hour_d = HOUR_W'(wrap_inc(6'(edit_hour_q), 6'(HOUR_MAX)));
          if (step_dn) edit_hour_d = HOUR_W'(wrap_dec(6'(edit_hour_q), 6'(HOUR_MAX)));
        end
        SET_MIN: begin
          if (step_up) edit_min_d = wrap_inc(edit_min_q, MIN_MAX);
          if (step_dn) edit_min_d = wrap_dec(edit_min_q, MIN_MAX);
        end
        default: begin
          if (step_up) edit_sec_d = wrap_inc(edit_sec_q, SEC_MAX);
          if (step_dn) edit_sec_d = wrap_dec(edit_sec_q, SEC_MAX);
        end
      endcase
      if (press_inc || press_dec) timeout_d = '0;
      else if (sec_pulse)         timeout_d = timeout_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      edit_sec_q   <= '0;
      edit_min_q   <= '0;
      edit_hour_q  <= '0;
      timeout_q    <= '0;
      load_q       <= 1'b0;
      load_sec_q   <= '0;
      load_min_q   <= '0;
      load_hour_q  <= '0;
      clk_enable_q <= 1'b1;
      edit_field_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      edit_sec_q   <= edit_sec_d;
      edit_min_q   <= edit_min_d;
      edit_hour_q  <= edit_hour_d;
      timeout_q    <= timeout_d;
      load_q       <= load_d;
      load_sec_q   <= load_sec_d;
      load_min_q   <= load_min_d;
      load_hour_q  <= load_hour_d;
      clk_enable_q <= (state_d == RUN);
      edit_field_q <= state_d;
    end
  end

  assign clk_enable = clk_enable_q;
  assign load       = load_q;
  assign load_sec   = load_sec_q;
  assign load_min   = load_min_q;
  assign load_hour  = load_hour_q;
  assign edit_field = edit_field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce and timeout settings.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sec_pulse = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [5:0] cur_sec = 6'd0;
  logic [5:0] cur_min = 6'd0;
  logic [4:0] cur_hour = 5'd0;
  logic       clk_enable;
  logic       load;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hour;
  logic [1:0] edit_field;

  int n_checks = 0;
  int n_fails = 0;
  int load_seen = 0;
  int press_seen = 0;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_SECS(3)) dut (
    .clk(clk), .reset_n(reset_n), .sec_pulse(sec_pulse),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .clk_enable(clk_enable), .load(load), .load_sec(load_sec),
    .load_min(load_min), .load_hour(load_hour), .edit_field(edit_field));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load === 1'b1) load_seen++;
    if (dut.press_inc === 1'b1) press_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_keys(input logic m, input logic i, input logic d);
    key_mode_n = ~m;
    key_inc_n  = ~i;
    key_dec_n  = ~d;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    set_keys(m, i, d);
    repeat (10) tick();
    set_keys(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
  endtask

  task automatic pulse_sec();
    sec_pulse = 1'b1;
    tick();
    sec_pulse = 1'b0;
    tick();
  endtask

  int load_tick;
  int ce_at_load;
  int ef_at_load;
  int base;
  int press_tick;

  initial begin
    // Asynchronous reset asserted between clock edges.
    #7 reset_n = 1'b0;
    #1;
    check("rst_clk_enable", clk_enable, 1);
    check("rst_edit_field", edit_field, 0);
    check("rst_load", load, 0);
    check("rst_load_time", {load_hour, load_min, load_sec}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Bounce on inc in RUN: 10 toggles 2 cycles apart, then held low.
    base = press_seen;
    for (int i = 0; i < 10; i++) begin
      key_inc_n = ~key_inc_n;
      repeat (2) tick();
    end
    key_inc_n = 1'b0;
    press_tick = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (dut.press_inc === 1'b1 && press_tick < 0) press_tick = k;
    end
    check("bounce_latency", press_tick, 7);
    key_inc_n = 1'b1;
    repeat (10) tick();
    check("bounce_press_count", press_seen - base, 1);
    check("run_ignores_inc", edit_field, 0);

    // Full edit 12:34:56 -> 00:59:00.
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    press(1'b1, 1'b0, 1'b0);
    check("enter_edit_field", edit_field, 1);
    check("enter_clk_enable", clk_enable, 0);
    check("capture_hour", dut.edit_hour_q, 12);
    repeat (12) press(1'b0, 1'b1, 1'b0);
    check("hour_wrap_inc", dut.edit_hour_q, 0);
    press(1'b1, 1'b0, 1'b0);
    check("min_edit_field", edit_field, 2);
    check("min_clk_enable", clk_enable, 0);
    repeat (35) press(1'b0, 1'b0, 1'b1);
    check("min_wrap_dec", dut.edit_min_q, 59);
    press(1'b1, 1'b0, 1'b0);
    check("sec_edit_field", edit_field, 3);
    repeat (4) press(1'b0, 1'b1, 1'b0);
    check("sec_wrap_inc", dut.edit_sec_q, 0);
    base = load_seen;
    load_tick = -1; ce_at_load = -1; ef_at_load = -1;
    set_keys(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (load === 1'b1 && load_tick < 0) begin
        load_tick = k;
        ce_at_load = clk_enable;
        ef_at_load = edit_field;
      end
    end
    set_keys(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    check("commit_load_tick", load_tick, 8);
    check("commit_load_count", load_seen - base, 1);
    check("commit_ce_with_load", ce_at_load, 1);
    check("commit_ef_with_load", ef_at_load, 0);
    check("commit_load_low_after", load, 0);
    check("commit_load_hour", load_hour, 0);
    check("commit_load_min", load_min, 59);
    check("commit_load_sec", load_sec, 0);
    check("commit_clk_enable", clk_enable, 1);

    // Simultaneous presses: mode+inc in SET_HOUR, inc+dec in SET_MIN.
    cur_hour = 5'd5; cur_min = 6'd10; cur_sec = 6'd20;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check("mode_inc_field", edit_field, 2);
    check("mode_inc_hour", dut.edit_hour_q, 5);
    press(1'b0, 1'b1, 1'b1);
    check("inc_dec_min", dut.edit_min_q, 10);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("simul_load_time", {load_hour, load_min, load_sec}, {5'd5, 6'd10, 6'd20});

    // Timeout with no keys.
    base = load_seen;
    cur_hour = 5'd7;
    press(1'b1, 1'b0, 1'b0);
    pulse_sec();
    pulse_sec();
    check("timeout_not_yet", edit_field, 1);
    pulse_sec();
    tick();
    check("timeout_field", edit_field, 0);
    check("timeout_clk_enable", clk_enable, 1);
    check("timeout_no_load", load_seen - base, 0);
    check("timeout_load_hold", load_hour, 5);

    // Timeout restarted by a key press after two pulses.
    press(1'b1, 1'b0, 1'b0);
    pulse_sec();
    pulse_sec();
    press(1'b0, 1'b1, 1'b0);
    pulse_sec();
    pulse_sec();
    check("timeout_restart_hold", edit_field, 1);
    pulse_sec();
    tick();
    check("timeout_restart_abort", edit_field, 0);
    check("timeout_restart_no_load", load_seen - base, 0);

    // Reset in the middle of an edit.
    cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("pre_reset_field", edit_field, 3);
    base = load_seen;
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_field", edit_field, 0);
    check("mid_rst_clk_enable", clk_enable, 1);
    check("mid_rst_load_time", {load_hour, load_min, load_sec}, 0);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("mid_rst_no_load", load_seen - base, 0);
    check("mid_rst_field_after", edit_field, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
